i2c_byte_master: RTL and testbench

I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_byte_master_if.sv | 25 ++
 rtl/i2c_tick_gen.sv | 36 +++
 rtl/i2c_byte_master.sv | 157 +++++++++++++++
 tb/tb_i2c_byte_master.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C opcodes and byte-engine state encodings
package i2c_pkg;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;

    localparam logic [1:0] Q_LAST   = 2'd3;
    localparam logic [2:0] BIT_LAST = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRBIT,
        ST_RDBIT,
        ST_ACKRX,
        ST_ACKTX,
        ST_STOP
    } state_e;

endpackage

// File: rtl/i2c_byte_master_if.sv
// rtl/i2c_byte_master_if.sv - command/response handshake and open-drain bus bundle
interface i2c_byte_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_mack;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_i;
    logic       sda_i;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, cmd_mack, scl_i, sda_i,
        output cmd_ready, rsp_valid, rsp_data, rsp_nack, scl_oe, sda_oe
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, cmd_mack, scl_i, sda_i,
        input  cmd_ready, rsp_valid, rsp_data, rsp_nack, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - quarter-period tick divider with enable and restart
module i2c_tick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en & (cnt_q == CNT_LAST);

    // next count: restart wins, wrap on tick, hold while disabled
    always_comb begin
        cnt_d = cnt_q;
        if (restart || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // divider counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - I2C byte-level master engine; I2C_CLK_STRETCH_EN enables SCL stretching
module i2c_byte_master #(
    parameter int CLK_DIV = 125
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_byte_master_if.master    bus
);
    import i2c_pkg::*;

    state_e     state_q, state_d;
    logic [1:0] q_q, q_d, q_next;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic       mack_q, mack_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_nack_q, rsp_nack_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       cmd_ready, accept, busy, stall, tick;

    assign busy      = (state_q != ST_IDLE);
    assign cmd_ready = ~busy & ~rsp_valid_q;
    assign accept    = bus.cmd_valid & cmd_ready;

`ifdef I2C_CLK_STRETCH_EN
    // a released SCL still read low means the slave is stretching the clock
    assign stall = busy & ~scl_oe_q & ~bus.scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = bus.scl_i;
    assign stall = 1'b0;
`endif

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .en      (busy & ~stall),
        .restart (accept | stall),
        .tick    (tick)
    );

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_nack  = rsp_nack_q;
    assign bus.scl_oe    = scl_oe_q;
    assign bus.sda_oe    = sda_oe_q;

    // bit/byte sequencing: q0 action applied at entry, later quarters on ticks
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        mack_d      = mack_q;
        scl_oe_d    = scl_oe_q;
        sda_oe_d    = sda_oe_q;
        rsp_data_d  = rsp_data_q;
        rsp_nack_d  = rsp_nack_q;
        rsp_valid_d = 1'b0;
        q_next      = q_q + 2'd1;
        if (!busy) begin
            if (accept) begin
                q_d        = 2'd0;
                bit_d      = 3'd0;
                shreg_d    = bus.cmd_data;
                mack_d     = bus.cmd_mack;
                rsp_nack_d = 1'b0;
                case (bus.cmd_op)
                    OP_START: begin state_d = ST_START; sda_oe_d = 1'b0; end
                    OP_STOP:  begin state_d = ST_STOP;  sda_oe_d = 1'b1; end
                    OP_WRITE: begin state_d = ST_WRBIT; sda_oe_d = ~bus.cmd_data[7]; end
                    default:  begin state_d = ST_RDBIT; sda_oe_d = 1'b0; end
                endcase
            end
        end else if (tick) begin
            if (q_q != Q_LAST) begin
                q_d = q_next;
                case (q_next)
                    2'd1: scl_oe_d = 1'b0;
                    2'd2: begin
                        case (state_q)
                            ST_START: sda_oe_d   = 1'b1;
                            ST_STOP:  sda_oe_d   = 1'b0;
                            ST_RDBIT: shreg_d    = {shreg_q[6:0], bus.sda_i};
                            ST_ACKRX: rsp_nack_d = bus.sda_i;
                            default:  ;
                        endcase
                    end
                    default: if (state_q != ST_STOP) scl_oe_d = 1'b1;
                endcase
            end else begin
                q_d = 2'd0;
                case (state_q)
                    ST_WRBIT: begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        if (bit_q == BIT_LAST) begin
                            state_d  = ST_ACKRX;
                            sda_oe_d = 1'b0;
                        end else begin
                            bit_d    = bit_q + 3'd1;
                            sda_oe_d = ~shreg_q[6];
                        end
                    end
                    ST_RDBIT: begin
                        if (bit_q == BIT_LAST) begin
                            state_d  = ST_ACKTX;
                            sda_oe_d = ~mack_q;
                        end else begin
                            bit_d    = bit_q + 3'd1;
                            sda_oe_d = 1'b0;
                        end
                    end
                    ST_ACKTX: begin
                        rsp_data_d  = shreg_q;
                        sda_oe_d    = 1'b0;
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                    end
                    default: begin
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // engine state and bus drive registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            q_q         <= 2'd0;
            bit_q       <= 3'd0;
            shreg_q     <= 8'd0;
            mack_q      <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_nack_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            mack_q      <= mack_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            rsp_data_q  <= rsp_data_d;
            rsp_nack_q  <= rsp_nack_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - directed self-checking bench for i2c_byte_master
module tb_i2c_byte_master;
    import i2c_pkg::*;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic slave_sda = 1'b1;
    logic stretch = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int         r_lat, r_wait, r_busy_ready;
    logic [8:0] r_got;
    logic [7:0] r_data;
    logic       r_nack, r_fall_hi, r_rise_hi, r_ack_drive, r_rdy_at_rsp, r_scl_at_issue;

    always #5 clk = ~clk;

    i2c_byte_master_if bus();

    i2c_byte_master #(.CLK_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.scl_i = ~bus.scl_oe & ~stretch;
    assign bus.sda_i = ~bus.sda_oe & slave_sda;

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic mack,
                           input logic [8:0] sb, input int stretch_bit);
        int   idx, st_left;
        logic st_done, pscl, psda, scl, sda;
        r_wait = 0;
        while (bus.cmd_ready !== 1'b1 && r_wait < 400) begin
            @(posedge clk); #1;
            r_wait++;
        end
        r_scl_at_issue = bus.scl_oe;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_mack  = mack;
        slave_sda = sb[8];
        idx = 0; st_left = 0; st_done = 1'b0;
        r_lat = -1; r_got = '0; r_fall_hi = 0; r_rise_hi = 0; r_ack_drive = 0; r_busy_ready = 0;
        r_nack = 1'bx; r_data = 'x; r_rdy_at_rsp = 1'bx;
        @(posedge clk); #1;
        pscl = ~bus.scl_oe & ~stretch;
        psda = bus.sda_i;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                bus.cmd_op   = op ^ 2'd1;
                bus.cmd_data = ~data;
                bus.cmd_mack = ~mack;
            end
            if (n == 5) bus.cmd_valid = 1'b0;
            if (bus.rsp_valid === 1'b1) begin
                r_lat = n; r_nack = bus.rsp_nack; r_data = bus.rsp_data; r_rdy_at_rsp = bus.cmd_ready;
                break;
            end
            if (bus.cmd_ready) r_busy_ready++;
            if (stretch_bit == idx && !st_done && !bus.scl_oe) begin
                stretch = 1'b1; st_left = 50; st_done = 1'b1;
            end else if (st_left > 0) begin
                st_left--;
                if (st_left == 0) stretch = 1'b0;
            end
            scl = ~bus.scl_oe & ~stretch;
            sda = bus.sda_i;
            if (scl && pscl && psda && !sda) r_fall_hi = 1'b1;
            if (scl && pscl && !psda && sda) r_rise_hi = 1'b1;
            if (!pscl && scl) r_got = {r_got[7:0], sda};
            if (pscl && !scl) begin
                idx++;
                slave_sda = (idx <= 8) ? sb[8-idx] : 1'b1;
            end
            if (idx == 8 && bus.sda_oe) r_ack_drive = 1'b1;
            pscl = scl;
            psda = sda;
        end
        bus.cmd_valid = 1'b0;
        stretch = 1'b0;
        slave_sda = 1'b1;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_START; bus.cmd_data = 8'h00; bus.cmd_mack = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (bus.scl_oe !== 1'b0)    begin n_bad++; $display("FAIL reset_scl_oe: got %b want 0", bus.scl_oe); end
        n_cmp++; if (bus.sda_oe !== 1'b0)    begin n_bad++; $display("FAIL reset_sda_oe: got %b want 0", bus.sda_oe); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== 8'h00) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 00", bus.rsp_data); end
        n_cmp++; if (bus.rsp_nack !== 1'b0)  begin n_bad++; $display("FAIL reset_rsp_nack: got %b want 0", bus.rsp_nack); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_start();
        run_cmd(OP_START, 8'h00, 1'b1, 9'h1FF, -1);
        n_cmp++; if (r_lat !== 16)        begin n_bad++; $display("FAIL start_latency: got %0d want 16", r_lat); end
        n_cmp++; if (r_fall_hi !== 1'b1)  begin n_bad++; $display("FAIL start_sda_fall_scl_high: got %b want 1", r_fall_hi); end
        n_cmp++; if (bus.scl_oe !== 1'b1) begin n_bad++; $display("FAIL start_scl_low_after: got %b want 1", bus.scl_oe); end
        n_cmp++; if (bus.sda_oe !== 1'b1) begin n_bad++; $display("FAIL start_sda_low_after: got %b want 1", bus.sda_oe); end
        n_cmp++; if (r_busy_ready !== 0)  begin n_bad++; $display("FAIL start_ready_while_busy: got %0d want 0", r_busy_ready); end
    endtask

    task automatic test_write_ack();
        run_cmd(OP_WRITE, 8'hA6, 1'b1, {8'hFF, 1'b0}, -1);
        n_cmp++; if (r_lat !== 144)             begin n_bad++; $display("FAIL write_latency: got %0d want 144", r_lat); end
        n_cmp++; if (r_got !== {8'hA6, 1'b0})   begin n_bad++; $display("FAIL write_a6_bits: got %h want %h", r_got, {8'hA6, 1'b0}); end
        n_cmp++; if (r_nack !== 1'b0)           begin n_bad++; $display("FAIL write_a6_nack: got %b want 0", r_nack); end
        n_cmp++; if (r_busy_ready !== 0)        begin n_bad++; $display("FAIL write_ready_while_busy: got %0d want 0", r_busy_ready); end
        n_cmp++; if (bus.scl_oe !== 1'b1)       begin n_bad++; $display("FAIL write_scl_low_after: got %b want 1", bus.scl_oe); end
    endtask

    task automatic test_write_nack();
        run_cmd(OP_WRITE, 8'h31, 1'b0, 9'h1FF, -1);
        n_cmp++; if (r_nack !== 1'b1)           begin n_bad++; $display("FAIL write_31_nack: got %b want 1", r_nack); end
        n_cmp++; if (r_got !== {8'h31, 1'b1})   begin n_bad++; $display("FAIL write_31_bits: got %h want %h", r_got, {8'h31, 1'b1}); end
        @(posedge clk); #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1)    begin n_bad++; $display("FAIL write_31_ready_after: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_read();
        run_cmd(OP_READ, 8'h00, 1'b1, {8'h5A, 1'b1}, -1);
        n_cmp++; if (r_lat !== 144)             begin n_bad++; $display("FAIL read_latency: got %0d want 144", r_lat); end
        n_cmp++; if (r_data !== 8'h5A)          begin n_bad++; $display("FAIL read_5a_data: got %h want 5a", r_data); end
        n_cmp++; if (r_ack_drive !== 1'b0)      begin n_bad++; $display("FAIL read_nack_sda_released: got %b want 0", r_ack_drive); end
        n_cmp++; if (r_nack !== 1'b0)           begin n_bad++; $display("FAIL read_rsp_nack: got %b want 0", r_nack); end
        n_cmp++; if (r_got !== {8'h5A, 1'b1})   begin n_bad++; $display("FAIL read_5a_bits: got %h want %h", r_got, {8'h5A, 1'b1}); end
    endtask

    task automatic test_stop();
        run_cmd(OP_STOP, 8'h00, 1'b0, 9'h1FF, -1);
        n_cmp++; if (r_lat !== 16)        begin n_bad++; $display("FAIL stop_latency: got %0d want 16", r_lat); end
        n_cmp++; if (r_rise_hi !== 1'b1)  begin n_bad++; $display("FAIL stop_sda_rise_scl_high: got %b want 1", r_rise_hi); end
        n_cmp++; if (bus.scl_oe !== 1'b0) begin n_bad++; $display("FAIL stop_scl_released: got %b want 0", bus.scl_oe); end
        n_cmp++; if (bus.sda_oe !== 1'b0) begin n_bad++; $display("FAIL stop_sda_released: got %b want 0", bus.sda_oe); end
    endtask

    task automatic test_back_to_back();
        run_cmd(OP_START, 8'h00, 1'b0, 9'h1FF, -1);
        n_cmp++; if (r_rdy_at_rsp !== 1'b0)     begin n_bad++; $display("FAIL b2b_ready_in_rsp_cycle: got %b want 0", r_rdy_at_rsp); end
        run_cmd(OP_WRITE, 8'h3C, 1'b1, {8'hFF, 1'b0}, -1);
        n_cmp++; if (r_wait !== 1)              begin n_bad++; $display("FAIL b2b_write_accept_wait: got %0d want 1", r_wait); end
        n_cmp++; if (r_scl_at_issue !== 1'b1)   begin n_bad++; $display("FAIL b2b_scl_low_gap: got %b want 1", r_scl_at_issue); end
        n_cmp++; if (r_got !== {8'h3C, 1'b0})   begin n_bad++; $display("FAIL b2b_write_3c_bits: got %h want %h", r_got, {8'h3C, 1'b0}); end
        run_cmd(OP_READ, 8'h00, 1'b0, {8'hC3, 1'b1}, -1);
        n_cmp++; if (r_wait !== 1)              begin n_bad++; $display("FAIL b2b_read_accept_wait: got %0d want 1", r_wait); end
        n_cmp++; if (r_data !== 8'hC3)          begin n_bad++; $display("FAIL b2b_read_c3_data: got %h want c3", r_data); end
        n_cmp++; if (r_ack_drive !== 1'b1)      begin n_bad++; $display("FAIL b2b_read_ack_driven: got %b want 1", r_ack_drive); end
        n_cmp++; if (r_got !== {8'hC3, 1'b0})   begin n_bad++; $display("FAIL b2b_read_c3_bits: got %h want %h", r_got, {8'hC3, 1'b0}); end
        run_cmd(OP_WRITE, 8'h81, 1'b1, {8'hFF, 1'b0}, -1);
        n_cmp++; if (r_data !== 8'hC3)          begin n_bad++; $display("FAIL b2b_rsp_data_held: got %h want c3", r_data); end
        run_cmd(OP_STOP, 8'h00, 1'b0, 9'h1FF, -1);
        n_cmp++; if (r_lat !== 16)              begin n_bad++; $display("FAIL b2b_stop_latency: got %0d want 16", r_lat); end
    endtask

    task automatic test_reset_mid();
        int   falls, seen, waited;
        logic pscl_oe;
        run_cmd(OP_START, 8'h00, 1'b0, 9'h1FF, -1);
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 400) begin @(posedge clk); #1; waited++; end
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_data = 8'h31; bus.cmd_mack = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        pscl_oe = bus.scl_oe;
        falls = 0;
        for (int n = 0; n < 400 && falls < 4; n++) begin
            @(posedge clk); #1;
            if (!pscl_oe && bus.scl_oe) falls++;
            pscl_oe = bus.scl_oe;
        end
        repeat (DIV) @(posedge clk);
        #2;
        n_cmp++; if (bus.scl_oe !== 1'b1) begin n_bad++; $display("FAIL mid_pre_scl_oe: got %b want 1", bus.scl_oe); end
        n_cmp++; if (bus.sda_oe !== 1'b1) begin n_bad++; $display("FAIL mid_pre_sda_oe_bit4: got %b want 1", bus.sda_oe); end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.scl_oe !== 1'b0) begin n_bad++; $display("FAIL mid_reset_scl_oe: got %b want 0", bus.scl_oe); end
        n_cmp++; if (bus.sda_oe !== 1'b0) begin n_bad++; $display("FAIL mid_reset_sda_oe: got %b want 0", bus.sda_oe); end
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (n == 1) reset = 1'b0;
            if (bus.rsp_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0)             begin n_bad++; $display("FAIL mid_no_rsp_valid: got %0d want 0", seen); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_after: got %b want 1", bus.cmd_ready); end
        run_cmd(OP_START, 8'h00, 1'b0, 9'h1FF, -1);
        n_cmp++; if (r_lat !== 16)           begin n_bad++; $display("FAIL mid_start_latency: got %0d want 16", r_lat); end
        n_cmp++; if (r_fall_hi !== 1'b1)     begin n_bad++; $display("FAIL mid_start_condition: got %b want 1", r_fall_hi); end
    endtask

`ifdef I2C_CLK_STRETCH_EN
    task automatic test_stretch();
        run_cmd(OP_WRITE, 8'h96, 1'b1, {8'hFF, 1'b0}, 3);
        n_cmp++; if (r_lat !== 194)           begin n_bad++; $display("FAIL stretch_latency: got %0d want 194", r_lat); end
        n_cmp++; if (r_got !== {8'h96, 1'b0}) begin n_bad++; $display("FAIL stretch_bits: got %h want %h", r_got, {8'h96, 1'b0}); end
        n_cmp++; if (r_nack !== 1'b0)         begin n_bad++; $display("FAIL stretch_nack: got %b want 0", r_nack); end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_write_ack();
        test_write_nack();
        test_read();
        test_stop();
        test_back_to_back();
        test_reset_mid();
`ifdef I2C_CLK_STRETCH_EN
        test_stretch();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
